// File: rtl/mux8_rr_sched_if.sv
// Handshake bundle between the requesters and the round-robin scheduler.
// The requester side (master) drives req/in. The scheduler side (slave) drives the grant and the serial output.
interface mux8_rr_sched_if;
    logic [7:0] req;
    logic [7:0] in;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out;
    logic       out_valid;
    logic       busy;

    modport master (
        output req,
        output in,
        input  sel,
        input  gnt,
        input  out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  in,
        output sel,
        output gnt,
        output out,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters.
// A grant is held for at most MAX_HOLD cycles, and the selected bit is registered onto a serial output.
module mux8_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_sched_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       sel_q;
    logic [2:0]       sel_next;
    logic [2:0]       ptr;
    logic [2:0]       ptr_next;
    logic [7:0]       gnt_q;
    logic [7:0]       gnt_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic             out_q;
    logic             out_valid_q;

    logic             any_req;
    logic             release_now;
    logic [2:0]       scan_start;
    logic [2:0]       winner;

    // Rotating-priority search: first set bit of mask starting at start, wrapping mod 8.
    function automatic logic [2:0] arb(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] result;
        logic [2:0] idx;
        logic       found;
        result = start;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    assign any_req     = |bus.req;
    assign release_now = !bus.req[sel_q] || (hold_cnt == CNT_W'(MAX_HOLD));
    assign scan_start  = (state == IDLE) ? ptr : (sel_q + 3'd1);
    assign winner      = arb(bus.req, scan_start);

    always_comb begin
        state_next = state;
        sel_next   = sel_q;
        gnt_next   = gnt_q;
        ptr_next   = ptr;
        hold_next  = hold_cnt;

        unique case (state)
            IDLE: begin
                gnt_next = 8'h00;
                if (any_req) begin
                    state_next = GRANT;
                    sel_next   = winner;
                    gnt_next   = 8'h01 << winner;
                    hold_next  = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_next = hold_cnt + CNT_W'(1);
                end else begin
                    // Hand over without an idle bubble. A lone requester that owns the line is re-granted, because the scan wraps back to it.
                    ptr_next = sel_q + 3'd1;
                    if (any_req) begin
                        sel_next  = winner;
                        gnt_next  = 8'h01 << winner;
                        hold_next = CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 8'h00;
                        hold_next  = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= 3'd0;
            gnt_q    <= 8'h00;
            ptr      <= 3'd0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            sel_q    <= sel_next;
            gnt_q    <= gnt_next;
            ptr      <= ptr_next;
            hold_cnt <= hold_next;
        end
    end

    // The output lags the grant by one cycle and samples the mux with the select that is currently registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= |gnt_q;
            out_q       <= (|gnt_q) ? bus.in[sel_q] : 1'b0;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == GRANT);

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));

    a_busy_matches_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        (state == GRANT) == (gnt_q != 8'h00));

    a_gnt_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_q == 8'h00) || (gnt_q == (8'h01 << sel_q)));

    a_hold_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        hold_cnt <= CNT_W'(MAX_HOLD));

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched. It uses directed scenarios plus randomized traffic.
// Two instances are compared against an owner/age reference model: one with MAX_HOLD=4 and one with MAX_HOLD=1.
module tb_mux8_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;

    int tests_run;
    int tests_failed;

    mux8_rr_sched_if bus4 ();
    mux8_rr_sched_if bus1 ();

    assign bus4.req = req;
    assign bus4.in  = din;
    assign bus1.req = req;
    assign bus1.in  = din;

    mux8_rr_sched #(.MAX_HOLD(4), .CNT_W(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux8_rr_sched #(.MAX_HOLD(1), .CNT_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the line, for how long they have owned it, and where the next scan starts.
    typedef struct {
        int owner;
        int age;
        int ptr;
        int sel;
        bit o;
        bit ov;
    } model_t;

    model_t m4;
    model_t m1;

    function automatic int first_req(logic [7:0] r, int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.age   = 0;
        m.ptr   = 0;
        m.sel   = 0;
        m.o     = 1'b0;
        m.ov    = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, logic [7:0] r, logic [7:0] d, int max_hold);
        model_t n;
        n    = m;
        n.ov = (m.owner >= 0);
        n.o  = (m.owner >= 0) ? d[m.owner] : 1'b0;
        if (m.owner < 0) begin
            if (r != 8'h00) begin
                n.owner = first_req(r, m.ptr);
                n.age   = 1;
                n.sel   = n.owner;
            end
        end else if (!r[m.owner] || m.age >= max_hold) begin
            n.ptr = (m.owner + 1) % 8;
            if (r != 8'h00) begin
                n.owner = first_req(r, n.ptr);
                n.age   = 1;
                n.sel   = n.owner;
            end else begin
                n.owner = -1;
            end
        end else begin
            n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] model_gnt(model_t m);
        return (m.owner < 0) ? 8'h00 : (8'h01 << m.owner);
    endfunction

    task automatic tick();
        @(posedge clk);
        m4 = model_step(m4, req, din, 4);
        m1 = model_step(m1, req, din, 1);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        din   = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m4    = model_reset();
        m1    = model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus4.gnt !== 8'h00 || bus4.sel !== 3'd0 || bus4.out !== 1'b0 ||
            bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut4: gnt=%h sel=%0d out=%b ov=%b busy=%b, required all 0",
                     bus4.gnt, bus4.sel, bus4.out, bus4.out_valid, bus4.busy);
        end
        tests_run++;
        if (bus1.gnt !== 8'h00 || bus1.sel !== 3'd0 || bus1.out !== 1'b0 ||
            bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut1: gnt=%h sel=%0d out=%b ov=%b busy=%b, required all 0",
                     bus1.gnt, bus1.sel, bus1.out, bus1.out_valid, bus1.busy);
        end
    endtask

    task automatic test_all_requesters();
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'hFF;
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_gnt = 8'h01 << (((k - 1) / 4) % 8);
            tests_run++;
            if (bus4.gnt !== exp_gnt || bus4.sel !== 3'(((k - 1) / 4) % 8) || bus4.busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL all_req cycle %0d: gnt=%h sel=%0d busy=%b, required gnt=%h sel=%0d busy=1",
                         k, bus4.gnt, bus4.sel, bus4.busy, exp_gnt, ((k - 1) / 4) % 8);
            end
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req = 8'h20;
        din = 8'b1010_1010;
        for (int k = 1; k <= 14; k++) begin
            tick();
            tests_run++;
            if (bus4.gnt !== 8'h20) begin
                tests_failed++;
                $display("[TB] FAIL single_gnt cycle %0d: gnt=%h, required 20", k, bus4.gnt);
            end
            if (k >= 2) begin
                tests_run++;
                if (bus4.out !== 1'b1 || bus4.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL single_out cycle %0d: out=%b ov=%b, required 1 1",
                             k, bus4.out, bus4.out_valid);
                end
            end
        end
    endtask

    task automatic test_two_requesters();
        int exp_owner;
        do_reset();
        req = 8'b1000_0001;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_owner = (((k - 1) / 4) % 2 == 1) ? 7 : 0;
            tests_run++;
            if (bus4.gnt !== (8'h01 << exp_owner)) begin
                tests_failed++;
                $display("[TB] FAIL alternate cycle %0d: gnt=%h, required %h",
                         k, bus4.gnt, 8'h01 << exp_owner);
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 8'h04;
        tick();
        tick();
        tests_run++;
        if (bus4.gnt !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL handoff_before: gnt=%h, required 04", bus4.gnt);
        end
        req = 8'h40;
        tick();
        tests_run++;
        if (bus4.gnt !== 8'h40 || bus4.busy !== 1'b1 || dut4.hold_cnt !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL handoff_after: gnt=%h busy=%b hold=%0d, required 40 1 1",
                     bus4.gnt, bus4.busy, dut4.hold_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'hFF;
        din = 8'hFF;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus4.gnt !== 8'h01 || bus4.out_valid !== 1'b1 || bus4.out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_async: gnt=%h ov=%b out=%b, required 01 1 1",
                     bus4.gnt, bus4.out_valid, bus4.out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus4.gnt !== 8'h00 || bus4.sel !== 3'd0 || bus4.out !== 1'b0 ||
            bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: gnt=%h sel=%0d out=%b ov=%b busy=%b, required all 0",
                     bus4.gnt, bus4.sel, bus4.out, bus4.out_valid, bus4.busy);
        end
        tests_run++;
        if (bus1.gnt !== 8'h00 || bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_dut1: gnt=%h ov=%b busy=%b, required all 0",
                     bus1.gnt, bus1.out_valid, bus1.busy);
        end
        @(negedge clk);
        m4    = model_reset();
        m1    = model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_every_cycle();
        logic [7:0] pattern;
        logic       exp_out;
        pattern = 8'b1111_0000;
        do_reset();
        din = pattern;
        req = 8'hFF;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_out = (k >= 2) ? pattern[(k - 2) % 8] : 1'b0;
            tests_run++;
            if (bus1.sel !== 3'((k - 1) % 8) || bus1.out !== exp_out ||
                bus1.out_valid !== (k >= 2)) begin
                tests_failed++;
                $display("[TB] FAIL rotate1 cycle %0d: sel=%0d out=%b ov=%b, required sel=%0d out=%b ov=%b",
                         k, bus1.sel, bus1.out, bus1.out_valid, (k - 1) % 8, exp_out, k >= 2);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 8'h00;
                    1:       req = 8'(1 << $urandom_range(0, 7));
                    2:       req = 8'($urandom) & 8'($urandom);
                    default: req = 8'($urandom);
                endcase
            end
            din = 8'($urandom);
            tick();
            tests_run++;
            if (bus4.gnt !== model_gnt(m4) || bus4.sel !== 3'(m4.sel) || bus4.out !== m4.o ||
                bus4.out_valid !== m4.ov || bus4.busy !== (m4.owner >= 0)) begin
                tests_failed++;
                $display("[TB] FAIL random4 step %0d: gnt=%h sel=%0d out=%b ov=%b busy=%b, required %h %0d %b %b %b",
                         k, bus4.gnt, bus4.sel, bus4.out, bus4.out_valid, bus4.busy,
                         model_gnt(m4), m4.sel, m4.o, m4.ov, m4.owner >= 0);
            end
            tests_run++;
            if (bus1.gnt !== model_gnt(m1) || bus1.sel !== 3'(m1.sel) || bus1.out !== m1.o ||
                bus1.out_valid !== m1.ov || bus1.busy !== (m1.owner >= 0)) begin
                tests_failed++;
                $display("[TB] FAIL random1 step %0d: gnt=%h sel=%0d out=%b ov=%b busy=%b, required %h %0d %b %b %b",
                         k, bus1.gnt, bus1.sel, bus1.out, bus1.out_valid, bus1.busy,
                         model_gnt(m1), m1.sel, m1.o, m1.ov, m1.owner >= 0);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req          = 8'h00;
        din          = 8'h00;
        m4           = model_reset();
        m1           = model_reset();

        test_reset();
        test_all_requesters();
        test_single_requester();
        test_two_requesters();
        test_handoff();
        test_async_reset();
        test_rotate_every_cycle();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
